weight_ram_arbiter: RTL and testbench

Shares the single weight block RAM between two requesters.
- Requester A is the inference read driver, which streams weights to the neural units.
- Requester B is a host/loader port, which reprograms or reads back weights between or during runs.
The block grants one access per cycle and tracks in-flight reads through the RAM read latency, returning data and a valid strobe to the correct owner. It sits between the read driver / host loader and the block RAM, in place of a direct address connection.

---
 rtl/weight_ram_arbiter.sv | 81 ++++++++
 tb/tb_weight_ram_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/weight_ram_arbiter.sv
// weight_ram_arbiter: shares one weight RAM between the read driver and the host loader, routing read data back by owner tag.
module weight_ram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int RD_LATENCY = 1,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              layer_busy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam int CW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXW = CW'(HOST_MAX_WAIT);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RD_LATENCY-1:0] tag_v_q, tag_v_d, tag_h_q, tag_h_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, host_rdata_q, host_rdata_d;
  logic rd_valid_q, rd_valid_d, host_valid_q, host_valid_d;
  logic host_el, host_win, rd_win, ret_v, ret_h;
  always_comb begin
    host_el = host_req && !(host_we && layer_busy);
    host_win = !reset && host_el && (!rd_req || wait_cnt_q == MAXW);
    rd_win = !reset && rd_req && !host_win;
    rd_gnt = rd_win;
    host_gnt = host_win;
    ram_en = rd_win || host_win;
    ram_we = host_win && host_we;
    ram_addr = host_win ? host_addr : rd_win ? rd_addr : '0;
    ram_din = ram_we ? host_wdata : '0;
    // a locked-out write holds the age counter rather than aging toward a force
    wait_cnt_d = (host_win || !host_req) ? '0 :
                 (host_el && wait_cnt_q != MAXW) ? wait_cnt_q + CW'(1) : wait_cnt_q;
    tag_v_d = RD_LATENCY'({tag_v_q, rd_win || (host_win && !host_we)});
    tag_h_d = RD_LATENCY'({tag_h_q, host_win});
    ret_v = tag_v_q[RD_LATENCY-1];
    ret_h = tag_h_q[RD_LATENCY-1];
    rd_valid_d = ret_v && !ret_h;
    host_valid_d = ret_v && ret_h;
    rd_data_d = rd_valid_d ? ram_dout : rd_data_q;
    host_rdata_d = host_valid_d ? ram_dout : host_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      tag_v_q <= '0;
      tag_h_q <= '0;
      rd_valid_q <= 1'b0;
      host_valid_q <= 1'b0;
      rd_data_q <= '0;
      host_rdata_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tag_v_q <= tag_v_d;
      tag_h_q <= tag_h_d;
      rd_valid_q <= rd_valid_d;
      host_valid_q <= host_valid_d;
      rd_data_q <= rd_data_d;
      host_rdata_q <= host_rdata_d;
    end
  end
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign host_rvalid = host_valid_q;
  assign host_rdata = host_rdata_q;
endmodule

// File: tb/tb_weight_ram_arbiter.sv
// tb_weight_ram_arbiter: directed checks of arbitration, lockout, starvation guard and return routing at RD_LATENCY 1 and 3.
module tb_weight_ram_arbiter;
  logic clk = 1'b0;
  logic reset, layer_busy, rd_req, host_req, host_we, preload;
  logic [6:0] rd_addr, host_addr;
  logic [7:0] host_wdata;
  logic rd_gnt1, rd_valid1, host_gnt1, host_rvalid1, ram_en1, ram_we1;
  logic rd_gnt3, rd_valid3, host_gnt3, host_rvalid3, ram_en3, ram_we3;
  logic [7:0] rd_data1, host_rdata1, ram_din1, ram_dout1, rd_data3, host_rdata3, ram_din3, ram_dout3;
  logic [6:0] ram_addr1, ram_addr3;
  logic [7:0] mem1 [128];
  logic [7:0] mem3 [128];
  logic [7:0] p3 [3];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  weight_ram_arbiter #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .layer_busy(layer_busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt1), .host_rdata(host_rdata1), .host_rvalid(host_rvalid1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_dout(ram_dout1));
  weight_ram_arbiter #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .layer_busy(layer_busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt3), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt3), .host_rdata(host_rdata3), .host_rvalid(host_rvalid3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_dout(ram_dout3));
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem1[i] <= 8'(i) ^ 8'h5A;
    end else if (ram_en1 && ram_we1) mem1[ram_addr1] <= ram_din1;
    ram_dout1 <= mem1[ram_addr1];
  end
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem3[i] <= 8'(i) ^ 8'h5A;
    end else if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_din3;
    p3[0] <= mem3[ram_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ram_dout3 = p3[2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rd_req = 0; host_req = 0; host_we = 0; rd_addr = 0; host_addr = 0; host_wdata = 0;
  endtask
  initial begin
    reset = 1; preload = 1; layer_busy = 0;
    idle();
    tick();
    preload = 0;
    tick();
    #1;
    chk("rst_rd_gnt", rd_gnt1, 0);
    chk("rst_host_gnt", host_gnt1, 0);
    chk("rst_ram_en", ram_en1, 0);
    chk("rst_ram_we", ram_we1, 0);
    chk("rst_rd_valid", rd_valid1, 0);
    chk("rst_host_rvalid", host_rvalid1, 0);
    chk("rst_rd_data", rd_data1, 0);
    chk("rst_host_rdata", host_rdata1, 0);
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      chk("idle_rd_valid", rd_valid1, 0);
      chk("idle_ram_en", ram_en1, 0);
    end
    // read-driver streaming, returns two cycles after each grant
    for (int i = 0; i < 11; i++) begin
      tick();
      rd_req = (i < 8); rd_addr = 7'(i);
      #1;
      chk("stream_rd_gnt", rd_gnt1, (i < 8));
      if (i < 8) chk("stream_ram_addr", ram_addr1, i);
      chk("stream_rd_valid", rd_valid1, (i >= 2 && i < 10));
      if (i >= 2 && i < 10) chk("stream_rd_data", rd_data1, (i - 2) ^ 8'h5A);
      chk("stream_host_rvalid", host_rvalid1, 0);
    end
    idle();
    // host write locked out while a layer is busy
    layer_busy = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      host_req = 1; host_we = 1; host_addr = 7'h10; host_wdata = 8'hC3;
      #1;
      chk("lock_host_gnt", host_gnt1, 0);
      chk("lock_ram_we", ram_we1, 0);
    end
    tick();
    layer_busy = 0;
    #1;
    chk("unlock_host_gnt", host_gnt1, 1);
    chk("unlock_ram_we", ram_we1, 1);
    chk("unlock_ram_addr", ram_addr1, 7'h10);
    chk("unlock_ram_din", ram_din1, 8'hC3);
    tick();
    host_we = 0; host_wdata = 0;
    #1;
    chk("hrd_host_gnt", host_gnt1, 1);
    chk("hrd_ram_we", ram_we1, 0);
    chk("hrd_ram_din", ram_din1, 0);
    tick();
    idle();
    #1;
    chk("hrd_early_rvalid", host_rvalid1, 0);
    tick(); #1;
    chk("hrd_rvalid", host_rvalid1, 1);
    chk("hrd_rdata", host_rdata1, 8'hC3);
    chk("hrd_no_rd_valid", rd_valid1, 0);
    tick(); #1;
    chk("hrd_pulse_once", host_rvalid1, 0);
    chk("hrd_rdata_hold", host_rdata1, 8'hC3);
    tick();
    // starvation guard: host forced ahead after HOST_MAX_WAIT losses
    for (int i = 0; i < 11; i++) begin
      tick();
      rd_req = 1; rd_addr = 7'h03;
      host_req = (i <= 8); host_we = 0; host_addr = 7'h20;
      #1;
      chk("starve_rd_gnt", rd_gnt1, (i != 8));
      chk("starve_host_gnt", host_gnt1, (i == 8));
      if (i == 9) chk("starve_rd_data_c9", rd_data1, 8'h59);
      if (i == 10) begin
        chk("starve_host_rvalid", host_rvalid1, 1);
        chk("starve_host_rdata", host_rdata1, 8'h7A);
        chk("starve_rd_gap", rd_valid1, 0);
      end
    end
    idle();
    tick(); tick(); tick();
    // interleaved rd/host reads at RD_LATENCY=3
    for (int i = 0; i < 12; i++) begin
      tick();
      rd_req = (i < 6) && (i % 2 == 0); rd_addr = 7'd1;
      host_req = (i < 6) && (i % 2 == 1); host_we = 0; host_addr = 7'd2;
      #1;
      if (i < 6) chk("ilv_gnt", {rd_gnt3, host_gnt3}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("ilv_rd_valid", rd_valid3, (i >= 4 && i < 10 && i % 2 == 0));
      chk("ilv_host_rvalid", host_rvalid3, (i >= 5 && i < 10 && i % 2 == 1));
      if (i >= 4 && i < 10 && i % 2 == 0) chk("ilv_rd_data", rd_data3, 8'h5B);
      if (i >= 5 && i < 10 && i % 2 == 1) chk("ilv_host_rdata", host_rdata3, 8'h58);
    end
    idle();
    tick();
    // reset while a read is in flight discards it
    tick();
    rd_req = 1; rd_addr = 7'd5;
    #1;
    chk("mid_rd_gnt", rd_gnt1, 1);
    tick();
    reset = 1;
    #1;
    chk("mid_rst_rd_gnt", rd_gnt1, 0);
    chk("mid_rst_ram_en", ram_en1, 0);
    for (int i = 2; i < 10; i++) begin
      tick();
      reset = 0;
      rd_req = (i == 4); rd_addr = 7'd6;
      #1;
      if (i == 2) chk("mid_rd_data_clr", rd_data1, 0);
      if (i == 4) chk("mid_new_gnt", rd_gnt1, 1);
      chk("mid_rd_valid1", rd_valid1, (i == 6));
      if (i == 6) chk("mid_rd_data1", rd_data1, 8'h5C);
      chk("mid_rd_valid3", rd_valid3, (i == 8));
      if (i == 8) chk("mid_rd_data3", rd_data3, 8'h5C);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
